mips32_debug_port: RTL

- Host-side debug/loader port for the pipelined MIPS32 core; the responder end of the host↔core access path used by test programs.
- Accepts commands over a valid/ready channel: instruction/data memory writes and reads, register file writes and reads, start and stop.
- Returns one response per command over a second valid/ready channel.
- Drives the core's memory/register access strobes and the run/PC-load controls, so benches and the host load programs and dump results without hierarchical pokes.

---
 rtl/mips32_debug_port.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mips32_debug_port.sv
// Host-side debug/loader responder for the MIPS32 core: one command in, one response out.
// Optional cycle counter for the CYCLES command is enabled by defining MIPS32_DBG_CYCLE_CNT_EN.
module mips32_debug_port #(
  parameter int MEM_AW = 10,
  parameter int REG_AW = 5
) (
  input  logic              clock1,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [MEM_AW-1:0] cmd_addr,
  input  logic [31:0]       cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              core_run,
  output logic              pc_load,
  output logic [31:0]       pc_value,
  input  logic              core_halted
);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_MEM_WR = 3'd1;
  localparam logic [2:0] OP_MEM_RD = 3'd2;
  localparam logic [2:0] OP_REG_WR = 3'd3;
  localparam logic [2:0] OP_REG_RD = 3'd4;
  localparam logic [2:0] OP_START  = 3'd5;
  localparam logic [2:0] OP_STOP   = 3'd6;
  localparam logic [2:0] OP_CYCLES = 3'd7;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                run_acc_q, run_acc_d;
  logic [31:0]         rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic                core_run_q, core_run_d;
  logic                stop_req;
  logic                idx_zero;
`ifdef MIPS32_DBG_CYCLE_CNT_EN
  logic [31:0]         cyc_q, cyc_d;
`endif

  assign idx_zero  = (addr_q[REG_AW-1:0] == '0);
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign reg_addr  = addr_q[REG_AW-1:0];
  assign reg_wdata = data_q;
  assign pc_value  = data_q;
  assign core_run  = core_run_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    run_acc_d  = run_acc_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    pc_load    = 1'b0;
    stop_req   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          run_acc_d  = core_run_q;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        state_d    = RESP;
        // Access guard uses the run state captured at accept, not the live one
        case (op_q)
          OP_MEM_WR: begin
            if (run_acc_q) rsp_err_d = 1'b1;
            else           mem_we    = 1'b1;
          end
          OP_MEM_RD, OP_REG_RD: begin
            rsp_err_d = run_acc_q;
            state_d   = RDWAIT;
          end
          OP_REG_WR: begin
            if (run_acc_q || idx_zero) rsp_err_d = 1'b1;
            else                       reg_we    = 1'b1;
          end
          OP_START: begin
            if (run_acc_q) rsp_err_d = 1'b1;
            else           pc_load   = 1'b1;
          end
          OP_STOP: stop_req = 1'b1;
          OP_CYCLES: begin
`ifdef MIPS32_DBG_CYCLE_CNT_EN
            rsp_data_d = cyc_q;
`else
            rsp_err_d  = 1'b1;
`endif
          end
          default: ;
        endcase
      end
      RDWAIT: begin
        if (!rsp_err_q) rsp_data_d = (op_q == OP_MEM_RD) ? mem_rdata : reg_rdata;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // START beats a stale halt; halt and STOP both clear the run flag
  always_comb begin
    core_run_d = core_run_q;
    if (core_run_q && core_halted) core_run_d = 1'b0;
    if (stop_req)                  core_run_d = 1'b0;
    if (pc_load)                   core_run_d = 1'b1;
  end

`ifdef MIPS32_DBG_CYCLE_CNT_EN
  always_comb begin
    cyc_d = cyc_q;
    if (pc_load)         cyc_d = '0;
    else if (core_run_q) cyc_d = cyc_q + 32'd1;
  end

  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end
`endif

  always_ff @(posedge clock1 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_NOP;
      addr_q     <= '0;
      data_q     <= '0;
      run_acc_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      core_run_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      run_acc_q  <= run_acc_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      core_run_q <= core_run_d;
    end
  end

endmodule
